// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-stage state encoding and control-bundle
// field positions used by the stages that pack/unpack the opaque bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } skid_state_t;

    // Control bundle bit positions (bundle is opaque to the skid stage itself)
    localparam int unsigned CTRL_REGWRITE  = 0;
    localparam int unsigned CTRL_MEMTOREG  = 1;
    localparam int unsigned CTRL_MEMREAD   = 2;
    localparam int unsigned CTRL_MEMWRITE  = 3;
    localparam int unsigned CTRL_ALUOP     = 4;
    localparam int unsigned CTRL_ALUSRC    = 5;
    localparam int unsigned CTRL_BRANCH    = 6;
    localparam int unsigned CTRL_PREDTAKEN = 7;
    localparam int unsigned CTRL_PACKED_W  = 8;

    // Beats held for a given state; the unused encoding reads as empty.
    function automatic logic [1:0] state_count(input skid_state_t s);
        case (s)
            S_FULL:  state_count = 2'd1;
            S_SKID:  state_count = 2'd2;
            default: state_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with one-entry skid buffer, registered ready and
// synchronous flush-as-bubble.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = 8,
    parameter int unsigned DATA_W     = 128,
    parameter bit          FLUSH_DATA = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    skid_state_t       state;
    skid_state_t       state_nxt;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              emit;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    // Handshake outputs decode the state register only
    assign ready_o = (state != S_SKID);
    assign valid_o = (state == S_FULL) || (state == S_SKID);
    assign ctrl_o  = valid_o ? main_ctrl : '0;
    assign data_o  = main_data;
    assign count_o = state_count(state);

    assign accept = valid_i & ready_o;
    assign emit   = valid_o & ready_i;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            S_FULL: begin
                if (accept && emit) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = S_SKID;
                end else if (emit) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_SKID: begin
                if (emit) begin
                    load_main_skid = 1'b1;
                    state_nxt      = S_FULL;
                end
            end
            default: begin
                // Also recovers the unused encoding back to empty
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = S_FULL;
                end else begin
                    state_nxt = S_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush_i) begin
            state     <= S_EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            if (FLUSH_DATA) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                main_ctrl <= ctrl_i;
                main_data <= data_i;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= ctrl_i;
                skid_data <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances (FLUSH_DATA=1 and 0) share stimulus
// and are checked against a queue-based occupancy model.
module tb_pipe_skid_stage;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 128;
    localparam int unsigned BW = CW + DW;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          valid_i;
    logic          ready_i;
    logic [CW-1:0] ctrl_i;
    logic [DW-1:0] data_i;

    logic          a_ready, a_valid, b_ready, b_valid;
    logic [CW-1:0] a_ctrl, b_ctrl;
    logic [DW-1:0] a_data, b_data;
    logic [1:0]    a_count, b_count;

    int checks = 0;
    int failures = 0;

    logic [BW-1:0] q[$];
    logic [BW-1:0] act_log[$];
    logic [BW-1:0] exp_log[$];

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_DATA(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i),
        .ready_o(a_ready), .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(a_valid),
        .ready_i(ready_i), .ctrl_o(a_ctrl), .data_o(a_data), .count_o(a_count)
    );

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_DATA(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i),
        .ready_o(b_ready), .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(b_valid),
        .ready_i(ready_i), .ctrl_o(b_ctrl), .data_o(b_data), .count_o(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running exp finished");
        $fatal(1, "watchdog");
    end

    // Advance one clock; the model holds at most two beats and is updated from
    // the handshake rules, while both emitted-beat logs are recorded.
    task automatic step();
        logic ready_m, valid_m, acc, emt;
        ready_m = (q.size() < 2);
        valid_m = (q.size() > 0);
        acc = valid_i && ready_m;
        emt = valid_m && ready_i;
        if (a_valid && ready_i && !rst) act_log.push_back({a_ctrl, a_data});
        if (emt && !rst) exp_log.push_back(q[0]);
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (emt) void'(q.pop_front());
            if (acc) q.push_back({ctrl_i, data_i});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b1; ready_i = 1'b1; flush = 1'b0;
        ctrl_i = 8'hFF; data_i = '1;
        step(); step();
        rst = 1'b0; valid_i = 1'b0;
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got %b/%b exp 0", a_valid, b_valid);
        end
        checks++;
        if (a_ctrl !== '0 || b_ctrl !== '0) begin
            failures++; $display("FAIL reset_ctrl got %h/%h exp 0", a_ctrl, b_ctrl);
        end
        checks++;
        if (a_data !== '0 || b_data !== '0) begin
            failures++; $display("FAIL reset_data got %h/%h exp 0", a_data, b_data);
        end
        checks++;
        if (a_count !== 2'd0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
            failures++; $display("FAIL reset_count_ready got count=%0d ready=%b exp count=0 ready=1", a_count, a_ready);
        end
    endtask

    task automatic test_streaming();
        ready_i = 1'b1; ctrl_i = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            valid_i = 1'b1; data_i = DW'(i);
            step();
            checks++;
            if (a_valid !== 1'b1 || a_data !== DW'(i) || a_ctrl !== 8'hA5 || a_count !== 2'd1) begin
                failures++;
                $display("FAIL stream_beat%0d got v=%b d=%h c=%h n=%0d exp v=1 d=%h c=a5 n=1",
                         i, a_valid, a_data, a_ctrl, a_count, DW'(i));
            end
        end
        valid_i = 1'b0;
        step();
        checks++;
        if (a_valid !== 1'b0 || a_count !== 2'd0 || a_ctrl !== 8'h00) begin
            failures++; $display("FAIL stream_drain got v=%b n=%0d c=%h exp v=0 n=0 c=00", a_valid, a_count, a_ctrl);
        end
    endtask

    task automatic test_stall();
        act_log.delete(); exp_log.delete();
        ctrl_i = 8'h3C;
        valid_i = 1'b1; ready_i = 1'b1; data_i = DW'(8'h11); step();
        ready_i = 1'b0; data_i = DW'(8'h22); step();
        data_i = DW'(8'h33);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (a_count !== 2'd2 || a_ready !== 1'b0 || a_data !== DW'(8'h11) || a_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d got n=%0d r=%b d=%h v=%b exp n=2 r=0 d=11 v=1",
                         i, a_count, a_ready, a_data, a_valid);
            end
            step();
        end
        checks++;
        if (a_data !== DW'(8'h11) || a_ready !== 1'b0) begin
            failures++; $display("FAIL stall_stable got d=%h r=%b exp d=11 r=0", a_data, a_ready);
        end
        ready_i = 1'b1;
        step();
        step();
        valid_i = 1'b0;
        step();
        step();
        checks++;
        if (act_log.size() != 3) begin
            failures++; $display("FAIL stall_count got %0d exp 3", act_log.size());
        end else if (act_log[0] !== {8'h3C, DW'(8'h11)} || act_log[1] !== {8'h3C, DW'(8'h22)}
                     || act_log[2] !== {8'h3C, DW'(8'h33)}) begin
            failures++;
            $display("FAIL stall_order got %h %h %h exp 11 22 33",
                     act_log[0][7:0], act_log[1][7:0], act_log[2][7:0]);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] b_prev;
        ready_i = 1'b1; valid_i = 1'b1; ctrl_i = 8'h5A; data_i = DW'(32'hAAAA_0001); step();
        ready_i = 1'b0; data_i = DW'(32'hAAAA_0002); step();
        checks++;
        if (a_count !== 2'd2) begin
            failures++; $display("FAIL flush_setup got n=%0d exp 2", a_count);
        end
        act_log.delete(); exp_log.delete();
        b_prev = b_data;
        flush = 1'b1; data_i = DW'(32'hDEAD_0099); step();
        flush = 1'b0; valid_i = 1'b0;
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_ctrl !== '0 || b_ctrl !== '0) begin
            failures++; $display("FAIL flush_bubble got v=%b/%b c=%h/%h exp v=0 c=00", a_valid, b_valid, a_ctrl, b_ctrl);
        end
        checks++;
        if (a_count !== 2'd0 || a_ready !== 1'b1 || b_count !== 2'd0 || b_ready !== 1'b1) begin
            failures++; $display("FAIL flush_state got n=%0d r=%b exp n=0 r=1", a_count, a_ready);
        end
        checks++;
        if (b_data !== b_prev || b_data !== DW'(32'hAAAA_0001)) begin
            failures++; $display("FAIL flush_keep_data got %h exp %h", b_data, b_prev);
        end
        checks++;
        if (a_data !== '0) begin
            failures++; $display("FAIL flush_zero_data got %h exp 0", a_data);
        end
        ready_i = 1'b1;
        step(); step();
        checks++;
        if (act_log.size() != 0) begin
            failures++; $display("FAIL flush_dropped got %0d beats exp 0", act_log.size());
        end
        valid_i = 1'b1; data_i = DW'(32'h0000_0777); step();
        valid_i = 1'b0;
        checks++;
        if (a_valid !== 1'b1 || a_data !== DW'(32'h777) || b_data !== DW'(32'h777)) begin
            failures++; $display("FAIL flush_reaccept got v=%b d=%h exp v=1 d=777", a_valid, a_data);
        end
        step();
    endtask

    task automatic test_random();
        act_log.delete(); exp_log.delete();
        for (int c = 0; c < 10000; c++) begin
            valid_i = ($urandom_range(0, 99) < 60);
            ready_i = ($urandom_range(0, 99) >= 30);
            flush   = ($urandom_range(0, 99) < 2);
            ctrl_i  = CW'($urandom);
            data_i  = {$urandom, $urandom, $urandom, $urandom};
            checks++;
            if (a_valid !== (q.size() > 0) || a_ready !== (q.size() < 2) || a_count !== 2'(q.size())) begin
                failures++;
                $display("FAIL rand_hs cyc%0d got v=%b r=%b n=%0d exp n=%0d", c, a_valid, a_ready, a_count, q.size());
            end
            checks++;
            if (b_valid !== a_valid || b_ready !== a_ready || b_count !== a_count || b_ctrl !== a_ctrl) begin
                failures++;
                $display("FAIL rand_pair cyc%0d got v=%b c=%h exp v=%b c=%h", c, b_valid, b_ctrl, a_valid, a_ctrl);
            end
            if (q.size() > 0) begin
                checks++;
                if ({a_ctrl, a_data} !== q[0] || b_data !== q[0][DW-1:0]) begin
                    failures++;
                    $display("FAIL rand_beat cyc%0d got %h exp %h", c, {a_ctrl, a_data}, q[0]);
                end
            end else begin
                checks++;
                if (a_ctrl !== '0) begin
                    failures++; $display("FAIL rand_bubble_ctrl cyc%0d got %h exp 00", c, a_ctrl);
                end
            end
            step();
        end
        flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        step(); step(); step();
        checks++;
        if (act_log.size() != exp_log.size() || act_log != exp_log) begin
            failures++; $display("FAIL rand_order got %0d beats exp %0d beats (or content differs)",
                                 act_log.size(), exp_log.size());
        end
    endtask

    task automatic test_reset_skid();
        ready_i = 1'b1; valid_i = 1'b1; ctrl_i = 8'h0F; data_i = DW'(16'hBEE1); step();
        ready_i = 1'b0; data_i = DW'(16'hBEE2); step();
        checks++;
        if (a_count !== 2'd2) begin
            failures++; $display("FAIL rskid_setup got n=%0d exp 2", a_count);
        end
        ready_i = 1'b1; rst = 1'b1; valid_i = 1'b0; step();
        rst = 1'b0;
        act_log.delete();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (act_log.size() != 0 || a_valid !== 1'b0 || a_count !== 2'd0 || a_ready !== 1'b1) begin
            failures++;
            $display("FAIL rskid_empty got beats=%0d v=%b n=%0d r=%b exp beats=0 v=0 n=0 r=1",
                     act_log.size(), a_valid, a_count, a_ready);
        end
        checks++;
        if (a_data !== '0 || b_data !== '0) begin
            failures++; $display("FAIL rskid_data got %h/%h exp 0", a_data, b_data);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        ctrl_i = '0; data_i = '0;
        #1;
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_random();
        test_reset_skid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register that replaces the fixed-field stage latches between decode, execute and memory. It carries an opaque control bundle and data bundle with a valid/ready handshake, absorbs a downstream stall through a one-entry skid buffer without a combinational ready path, and implements flush as a synchronous bubble insert. It sits between any two pipeline stages; producer on the `_i` side, consumer on the `_o` side.

## Interface
- `CTRL_W`, 8: width of control bundle (RegWrite, MemRead, Branch, ... packed by the instantiating stage).
- `DATA_W`, 128: width of data bundle (operands, immediate, PCs, register addresses).
- `FLUSH_DATA`, 1: 1 = flush and reset zero the data bundle; 0 = flush clears only valid and control, data holds.

- `clk_i` input 1: clock; all state on rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `flush_i` input 1: discard all held and incoming beats this cycle.
- `valid_i` input 1: producer has a beat.
- `ready_o` output 1: stage can accept a beat; registered.
- `ctrl_i` input CTRL_W: control bundle in.
- `data_i` input DATA_W: data bundle in.
- `valid_o` output 1: output beat valid.
- `ready_i` input 1: consumer accepts output beat.
- `ctrl_o` output CTRL_W: control bundle out; 0 whenever `valid_o`=0.
- `data_o` output DATA_W: data bundle out.
- `count_o` output 2: beats held (0, 1, 2).

## Operation
- Two entries: main (drives outputs) and skid. Accept = `valid_i & ready_o`; emit = `valid_o & ready_i`.
- States: S_EMPTY (count 0), S_FULL (main valid), S_SKID (main + skid valid).
- S_EMPTY: accept -> main <= in, S_FULL; else stay.
- S_FULL: accept & emit -> main <= in, stay; accept & !emit -> skid <= in, S_SKID; !accept & emit -> S_EMPTY; neither -> hold.
- S_SKID: emit -> main <= skid, S_FULL; else hold. `ready_o`=0, so no accept possible.
- `ready_o` = 1 in S_EMPTY and S_FULL, 0 in S_SKID; decoded from state register only.
- `valid_o` = 1 in S_FULL and S_SKID.
- Output stability: while `valid_o`=1 and `ready_i`=0, `ctrl_o`/`data_o` hold bit-exact.
- Order preserved: beats leave in acceptance order; no beat lost or duplicated except on flush.
- Flush (priority below reset, above all else): next state S_EMPTY, both entries' control cleared to 0, data cleared if FLUSH_DATA=1; beat presented with `valid_i` in the flush cycle is dropped; an output beat emitted in the flush cycle counts as consumed by the consumer.
- `ctrl_o` forced to 0 when invalid, so downstream sees a bubble (no RegWrite/MemWrite) without gating.

## Timing
- Reset: `valid_o`=0, `ctrl_o`=0, `data_o`=0, `count_o`=0, `ready_o`=1 from the cycle after `rst_i` sampled high; reset mid-transfer discards everything.
- Latency: beat accepted in cycle N appears on `valid_o` in N+1 (S_EMPTY or S_FULL-with-emit). From skid: one extra cycle per stall cycle.
- Throughput: 1 beat/cycle with `ready_i` held high.
- `ready_o` depends on state only: no combinational path from `ready_i` or `valid_i` to `ready_o`.
- All outputs registered or decoded from registers; no input-to-output combinational path.
- Flush in cycle N: `valid_o`=0, `ready_o`=1, `count_o`=0 in N+1; accept possible in N+1.
- Simultaneous flush + reset: reset outcome (identical except data zeroed regardless of FLUSH_DATA).

## Structure
- Shared package `pipe_pkg`: `skid_state_t` enum {S_EMPTY=2'd0, S_FULL=2'd1, S_SKID=2'd2}; 2'd3 illegal, decoded as S_EMPTY.
- Control field packing constants (bit positions of RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, Branch, predTaken) live in `pipe_pkg` for instantiating stages; this block treats bundles as opaque.
- No sub-module; main and skid entries are inline registers.

## Test plan
- Reset: assert `rst_i` 2 cycles with `valid_i`=1 -> `valid_o`=0, `ctrl_o`=0, `data_o`=0, `count_o`=0, `ready_o`=1.
- Streaming: 16 beats `data_i`=0..15, `ctrl_i`=8'hA5, `ready_i`=1 -> each beat out exactly one cycle later, `count_o`=1 throughout, no gaps.
- Stall: send beats 0x11, 0x22, 0x33 back-to-back, `ready_i`=0 from the 2nd cycle for 3 cycles -> `count_o` reaches 2, `ready_o`=0, 0x33 held by producer, `data_o`=0x11 stable; release -> order 0x11, 0x22, 0x33.
- Flush while S_SKID with `valid_i`=1 -> next cycle `valid_o`=0, `ctrl_o`=0, `count_o`=0, `ready_o`=1; incoming beat never appears; FLUSH_DATA=0 build: `data_o` unchanged.
- Random valid/ready (10k cycles, 30% stall, 2% flush) against scoreboard -> in-order, no loss outside flush, `ctrl_o`=0 whenever `valid_o`=0.
- Reset asserted in S_SKID with `ready_i`=1 -> no beat emitted after reset, state S_EMPTY.
